nh_lcd_init_sequencer: RTL and testbench

Autonomous power-up and initialisation engine that sits directly upstream of `nh_lcd`. It drives the display-reset, chip-select, command-strobe and data/command-mode controls of `nh_lcd` from a small command ROM. It pulses the panel reset, issues the controller init commands with their parameters and millisecond delays, and finishes with a memory-write command. It then hands the bus to the pixel data path by asserting data-command mode.

---
 rtl/nh_lcd_init_pkg.sv | 73 +++++++
 rtl/nh_lcd_init_rom.sv | 31 +++
 rtl/nh_lcd_init_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_nh_lcd_init_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nh_lcd_init_pkg.sv
`default_nettype none
// ============================================================================
// Module  : nh_lcd_init_pkg
// Brief   : Shared constants, ROM entry types and FSM encoding for the
//           nh_lcd power-up / initialisation sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package nh_lcd_init_pkg;

    localparam logic [1:0] c_type_cmd   = 2'd0;
    localparam logic [1:0] c_type_param = 2'd1;
    localparam logic [1:0] c_type_delay = 2'd2;
    localparam logic [1:0] c_type_end   = 2'd3;

    localparam logic [7:0] c_op_swreset = 8'h01;
    localparam logic [7:0] c_op_slpout  = 8'h11;
    localparam logic [7:0] c_op_colmod  = 8'h3A;
    localparam logic [7:0] c_op_madctl  = 8'h36;
    localparam logic [7:0] c_op_dispon  = 8'h29;
    localparam logic [7:0] c_op_caset   = 8'h2A;
    localparam logic [7:0] c_op_paset   = 8'h2B;
    localparam logic [7:0] c_op_ramwr   = 8'h2C;

    localparam int c_rom_depth = 10;
    localparam int c_rom_aw    = 4;
    localparam int c_win_len   = 10;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_RST_ASSERT = 4'd1,
        ST_RST_WAIT   = 4'd2,
        ST_FETCH      = 4'd3,
        ST_DECODE     = 4'd4,
        ST_ISSUE      = 4'd5,
        ST_WAIT_ACK   = 4'd6,
        ST_DELAY      = 4'd7,
        ST_FINAL      = 4'd8,
        ST_DONE       = 4'd9,
`ifdef NH_LCD_INIT_WINDOW_EN
        ST_WINDOW     = 4'd11,
`endif
        ST_ERROR      = 4'd10
    } state_t;

    // Which byte source the current ISSUE/WAIT_ACK handshake belongs to.
    typedef enum logic [1:0] {
        PH_ROM   = 2'd0,
        PH_WIN   = 2'd1,
        PH_FINAL = 2'd2
    } phase_t;

    function automatic logic [7:0] window_byte(input logic [3:0]  idx,
                                               input logic [15:0] w_last,
                                               input logic [15:0] h_last);
        logic [7:0] b;
        case (idx)
            4'd0:    b = c_op_caset;
            4'd3:    b = w_last[15:8];
            4'd4:    b = w_last[7:0];
            4'd5:    b = c_op_paset;
            4'd8:    b = h_last[15:8];
            4'd9:    b = h_last[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic window_is_param(input logic [3:0] idx);
        return (idx != 4'd0) && (idx != 4'd5);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nh_lcd_init_rom.sv
`default_nettype none
// ============================================================================
// Module  : nh_lcd_init_rom
// Brief   : Synchronous init-command ROM, one-cycle read latency.
// Revision: 1.0 - initial release
// ============================================================================
module nh_lcd_init_rom
    import nh_lcd_init_pkg::*;
(
    input  logic                clk,
    input  logic [c_rom_aw-1:0] i_addr,
    output logic [9:0]          o_entry
);

    always_ff @(posedge clk) begin
        case (i_addr)
            4'd0:    o_entry <= {c_type_cmd,   c_op_swreset};
            4'd1:    o_entry <= {c_type_delay, 8'd5};
            4'd2:    o_entry <= {c_type_cmd,   c_op_slpout};
            4'd3:    o_entry <= {c_type_delay, 8'd120};
            4'd4:    o_entry <= {c_type_cmd,   c_op_colmod};
            4'd5:    o_entry <= {c_type_param, 8'h55};
            4'd6:    o_entry <= {c_type_cmd,   c_op_madctl};
            4'd7:    o_entry <= {c_type_param, 8'h00};
            4'd8:    o_entry <= {c_type_cmd,   c_op_dispon};
            default: o_entry <= {c_type_end,   8'h00};
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/nh_lcd_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : nh_lcd_init_sequencer
// Brief   : Panel reset, ROM-driven init commands and RAMWR hand-off for nh_lcd.
//           Define NH_LCD_INIT_WINDOW_EN to also program the CASET/PASET window.
// Revision: 1.0 - initial release
// ============================================================================
module nh_lcd_init_sequencer
    import nh_lcd_init_pkg::*;
#(
    parameter int CYCLES_PER_MS  = 100000,
    parameter int RESET_PULSE_MS = 10,
    parameter int RESET_WAIT_MS  = 120,
    parameter int CMD_TIMEOUT    = 1024,
    parameter int SCREEN_WIDTH   = 480,
    parameter int SCREEN_HEIGHT  = 272
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error,
    output logic       o_reset_display,
    output logic       o_chip_select,
    output logic       o_data_command_mode,
    output logic       o_cmd_write_stb,
    output logic       o_cmd_parameter,
    output logic [7:0] o_cmd_data,
    input  logic       i_cmd_finished
);

    localparam int CW = $clog2(CYCLES_PER_MS);
    localparam int TW = $clog2(CMD_TIMEOUT + 1);
    localparam logic [CW-1:0] c_cyc_last    = CW'(CYCLES_PER_MS - 1);
    localparam logic [TW-1:0] c_to_last     = TW'(CMD_TIMEOUT - 1);
    localparam logic [7:0]    c_pulse_ms    = 8'(RESET_PULSE_MS);
    localparam logic [7:0]    c_wait_ms     = 8'(RESET_WAIT_MS);
`ifdef NH_LCD_INIT_WINDOW_EN
    localparam logic [15:0]   c_w_last      = 16'(SCREEN_WIDTH - 1);
    localparam logic [15:0]   c_h_last      = 16'(SCREEN_HEIGHT - 1);
    logic [3:0]               r_win_idx;
`endif

    state_t              r_state;
    phase_t              r_phase;
    logic [c_rom_aw-1:0] r_addr;
    logic [CW-1:0]       r_cyc;
    logic [7:0]          r_ms;
    logic [7:0]          r_ms_target;
    logic [TW-1:0]       r_to;
    logic [9:0]          w_entry;
    logic [1:0]          w_type;
    logic [7:0]          w_data;
    logic                w_ms_tick;
    logic                w_delay_done;

    nh_lcd_init_rom u_rom (
        .clk     (clk),
        .i_addr  (r_addr),
        .o_entry (w_entry)
    );

    assign w_type       = w_entry[9:8];
    assign w_data       = w_entry[7:0];
    assign w_ms_tick    = (r_cyc == c_cyc_last);
    assign w_delay_done = w_ms_tick && (r_ms == (r_ms_target - 8'd1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state             <= ST_IDLE;
            r_phase             <= PH_ROM;
            r_addr              <= '0;
            r_cyc               <= '0;
            r_ms                <= '0;
            r_ms_target         <= '0;
            r_to                <= '0;
`ifdef NH_LCD_INIT_WINDOW_EN
            r_win_idx           <= '0;
`endif
            o_busy              <= 1'b0;
            o_done              <= 1'b0;
            o_error             <= 1'b0;
            o_reset_display     <= 1'b0;
            o_chip_select       <= 1'b0;
            o_data_command_mode <= 1'b0;
            o_cmd_write_stb     <= 1'b0;
            o_cmd_parameter     <= 1'b0;
            o_cmd_data          <= '0;
        end else begin
            // Shared ms timebase; only meaningful in the counting states.
            if (w_ms_tick) begin
                r_cyc <= '0;
                r_ms  <= r_ms + 8'd1;
            end else begin
                r_cyc <= r_cyc + CW'(1);
            end

            case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (i_start) begin
                        o_done              <= 1'b0;
                        o_error             <= 1'b0;
                        o_busy              <= 1'b1;
                        o_reset_display     <= 1'b1;
                        o_chip_select       <= 1'b0;
                        o_data_command_mode <= 1'b0;
                        r_addr              <= '0;
                        r_phase             <= PH_ROM;
                        r_cyc               <= '0;
                        r_ms                <= '0;
                        r_ms_target         <= c_pulse_ms;
                        r_state             <= ST_RST_ASSERT;
                    end
                end
                ST_RST_ASSERT: begin
                    if (w_delay_done) begin
                        o_reset_display <= 1'b0;
                        r_cyc           <= '0;
                        r_ms            <= '0;
                        r_ms_target     <= c_wait_ms;
                        r_state         <= ST_RST_WAIT;
                    end
                end
                ST_RST_WAIT: begin
                    if (w_delay_done) begin
                        o_chip_select <= 1'b1;
                        r_state       <= ST_FETCH;
                    end
                end
                ST_FETCH: r_state <= ST_DECODE;
                ST_DECODE: begin
                    case (w_type)
                        c_type_cmd, c_type_param: begin
                            o_cmd_data      <= w_data;
                            o_cmd_parameter <= (w_type == c_type_param);
                            o_cmd_write_stb <= 1'b1;
                            r_state         <= ST_ISSUE;
                        end
                        c_type_delay: begin
                            if (w_data == 8'd0) begin
                                r_addr  <= r_addr + 1'b1;
                                r_state <= ST_FETCH;
                            end else begin
                                r_cyc       <= '0;
                                r_ms        <= '0;
                                r_ms_target <= w_data;
                                r_state     <= ST_DELAY;
                            end
                        end
                        default: begin
`ifdef NH_LCD_INIT_WINDOW_EN
                            r_win_idx <= '0;
                            r_phase   <= PH_WIN;
                            r_state   <= ST_WINDOW;
`else
                            r_state   <= ST_FINAL;
`endif
                        end
                    endcase
                end
                ST_DELAY: begin
                    if (w_delay_done) begin
                        r_addr  <= r_addr + 1'b1;
                        r_state <= ST_FETCH;
                    end
                end
`ifdef NH_LCD_INIT_WINDOW_EN
                ST_WINDOW: begin
                    o_cmd_data      <= window_byte(r_win_idx, c_w_last, c_h_last);
                    o_cmd_parameter <= window_is_param(r_win_idx);
                    o_cmd_write_stb <= 1'b1;
                    r_state         <= ST_ISSUE;
                end
`endif
                ST_FINAL: begin
                    o_cmd_data      <= c_op_ramwr;
                    o_cmd_parameter <= 1'b0;
                    o_cmd_write_stb <= 1'b1;
                    r_phase         <= PH_FINAL;
                    r_state         <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    o_cmd_write_stb <= 1'b0;
                    r_to            <= '0;
                    r_state         <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    // The acknowledge is tested first so it wins a tie with the timeout.
                    if (i_cmd_finished) begin
                        case (r_phase)
                            PH_FINAL: begin
                                o_done              <= 1'b1;
                                o_busy              <= 1'b0;
                                o_data_command_mode <= 1'b1;
                                r_state             <= ST_DONE;
                            end
`ifdef NH_LCD_INIT_WINDOW_EN
                            PH_WIN: begin
                                if (r_win_idx == 4'(c_win_len - 1)) begin
                                    r_state <= ST_FINAL;
                                end else begin
                                    r_win_idx <= r_win_idx + 4'd1;
                                    r_state   <= ST_WINDOW;
                                end
                            end
`endif
                            default: begin
                                r_addr  <= r_addr + 1'b1;
                                r_state <= ST_FETCH;
                            end
                        endcase
                    end else if (r_to == c_to_last) begin
                        o_error             <= 1'b1;
                        o_busy              <= 1'b0;
                        o_chip_select       <= 1'b0;
                        o_data_command_mode <= 1'b0;
                        r_state             <= ST_ERROR;
                    end else begin
                        r_to <= r_to + TW'(1);
                    end
                end
                default: begin
                    o_error             <= 1'b1;
                    o_busy              <= 1'b0;
                    o_chip_select       <= 1'b0;
                    o_data_command_mode <= 1'b0;
                    o_cmd_write_stb     <= 1'b0;
                    r_state             <= ST_ERROR;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nh_lcd_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_nh_lcd_init_sequencer
// Brief   : Directed self-checking bench for nh_lcd_init_sequencer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_nh_lcd_init_sequencer;

    localparam int CPM = 10;
    localparam int TO  = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_start = 1'b0;
    logic       i_cmd_finished = 1'b0;
    logic       o_busy, o_done, o_error, o_reset_display, o_chip_select;
    logic       o_data_command_mode, o_cmd_write_stb, o_cmd_parameter;
    logic [7:0] o_cmd_data;

    nh_lcd_init_sequencer #(
        .CYCLES_PER_MS (CPM),
        .CMD_TIMEOUT   (TO)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_start             (i_start),
        .o_busy              (o_busy),
        .o_done              (o_done),
        .o_error             (o_error),
        .o_reset_display     (o_reset_display),
        .o_chip_select       (o_chip_select),
        .o_data_command_mode (o_data_command_mode),
        .o_cmd_write_stb     (o_cmd_write_stb),
        .o_cmd_parameter     (o_cmd_parameter),
        .o_cmd_data          (o_cmd_data),
        .i_cmd_finished      (i_cmd_finished)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [8:0] strobes[$];
    int         strobe_t[$];
    logic [8:0] exp_q[$];
    int   rd_high_cnt, t_rd_fall, t_cs_rise, t_err;
    logic rd_prev = 1'b0, cs_prev = 1'b0;

    // Acknowledge model: default 2 cycles after strobe; one opcode may be special.
    int         ack_delay = 2;
    bit         special_en = 1'b0;
    logic [7:0] special_data = 8'h00;
    int         special_delay = 0;
    int         resp_d;
    logic [8:0] resp_cap;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (o_cmd_write_stb) begin
            strobes.push_back({o_cmd_parameter, o_cmd_data});
            strobe_t.push_back(cyc);
        end
        if (o_reset_display) rd_high_cnt++;
        if (rd_prev && !o_reset_display && t_rd_fall < 0) t_rd_fall = cyc;
        if (o_chip_select && !cs_prev && t_cs_rise < 0) t_cs_rise = cyc;
        if (o_error && t_err < 0) t_err = cyc;
        rd_prev = o_reset_display;
        cs_prev = o_chip_select;
    end

    initial forever begin
        @(negedge clk);
        if (o_cmd_write_stb && rst) begin
            resp_cap = {o_cmd_parameter, o_cmd_data};
            resp_d = (special_en && !o_cmd_parameter && o_cmd_data == special_data)
                     ? special_delay : ack_delay;
            if (resp_d > 0) begin
                repeat (resp_d) @(negedge clk);
                if (rst && o_busy) begin
                    checks++;
                    if ({o_cmd_parameter, o_cmd_data} !== resp_cap) begin
                        errors++;
                        $display("FAIL cmd_hold: got %03h want %03h",
                                 {o_cmd_parameter, o_cmd_data}, resp_cap);
                    end
                end
                i_cmd_finished = 1'b1;
                @(negedge clk);
                i_cmd_finished = 1'b0;
            end
        end
    end

    task automatic clear_log();
        strobes.delete();
        strobe_t.delete();
        rd_high_cnt = 0;
        t_rd_fall   = -1;
        t_cs_rise   = -1;
        t_err       = -1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_end(input int bound, output bit expired);
        int n = 0;
        expired = 1'b0;
        while (!(o_done || o_error)) begin
            @(negedge clk);
            n++;
            if (n >= bound) begin
                expired = 1'b1;
                break;
            end
        end
    endtask

    task automatic build_expected();
        exp_q.delete();
        exp_q.push_back(9'h001); exp_q.push_back(9'h011);
        exp_q.push_back(9'h03A); exp_q.push_back(9'h155);
        exp_q.push_back(9'h036); exp_q.push_back(9'h100);
        exp_q.push_back(9'h029);
`ifdef NH_LCD_INIT_WINDOW_EN
        exp_q.push_back(9'h02A); exp_q.push_back(9'h100); exp_q.push_back(9'h100);
        exp_q.push_back(9'h101); exp_q.push_back(9'h1DF);
        exp_q.push_back(9'h02B); exp_q.push_back(9'h100); exp_q.push_back(9'h100);
        exp_q.push_back(9'h101); exp_q.push_back(9'h10F);
`endif
        exp_q.push_back(9'h02C);
    endtask

    function automatic logic [15:0] out_vec();
        return {o_busy, o_done, o_error, o_reset_display, o_chip_select,
                o_data_command_mode, o_cmd_write_stb, o_cmd_parameter, o_cmd_data};
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (out_vec() !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs: got %04h want 0000", out_vec());
        end
        rst = 1'b1;
        clear_log();
        repeat (20) @(negedge clk);
        checks++;
        if (out_vec() !== 16'h0000 || strobes.size() != 0) begin
            errors++;
            $display("FAIL idle_after_reset: got %04h strobes %0d want 0000 0",
                     out_vec(), strobes.size());
        end
    endtask

    task automatic test_normal();
        bit expired;
        clear_log();
        pulse_start();
        wait_end(6000, expired);
        checks++;
        if (expired) begin
            errors++;
            $display("FAIL normal_finish: got timeout want done");
        end
        checks++;
        if (rd_high_cnt != 100) begin
            errors++;
            $display("FAIL reset_pulse_len: got %0d want 100", rd_high_cnt);
        end
        checks++;
        if (t_cs_rise - t_rd_fall != 1200) begin
            errors++;
            $display("FAIL reset_wait_len: got %0d want 1200", t_cs_rise - t_rd_fall);
        end
        checks++;
        if (strobes.size() != exp_q.size()) begin
            errors++;
            $display("FAIL strobe_count: got %0d want %0d", strobes.size(), exp_q.size());
        end
        for (int i = 0; i < strobes.size() && i < exp_q.size(); i++) begin
            checks++;
            if (strobes[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL strobe_%0d: got %03h want %03h", i, strobes[i], exp_q[i]);
            end
        end
        checks++;
        if (strobe_t.size() < 3) begin
            errors++;
            $display("FAIL delay_gaps: got %0d strobes want >=3", strobe_t.size());
        end else begin
            if (strobe_t[1] - strobe_t[0] < 50 || strobe_t[1] - strobe_t[0] > 60) begin
                errors++;
                $display("FAIL gap_after_01: got %0d want 50..60", strobe_t[1] - strobe_t[0]);
            end
            checks++;
            if (strobe_t[2] - strobe_t[1] < 1200 || strobe_t[2] - strobe_t[1] > 1210) begin
                errors++;
                $display("FAIL gap_after_11: got %0d want 1200..1210",
                         strobe_t[2] - strobe_t[1]);
            end
        end
        checks++;
        if ({o_done, o_data_command_mode, o_chip_select, o_busy, o_error} !== 5'b11100) begin
            errors++;
            $display("FAIL done_state: got %05b want 11100",
                     {o_done, o_data_command_mode, o_chip_select, o_busy, o_error});
        end
    endtask

    task automatic test_start_ignored();
        bit expired;
        int n = 0;
        clear_log();
        pulse_start();
        while (strobes.size() < 3 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        wait_end(6000, expired);
        checks++;
        if (expired || !o_done) begin
            errors++;
            $display("FAIL start_ignored_finish: got done=%0b want 1", o_done);
        end
        checks++;
        if (strobes.size() != exp_q.size()) begin
            errors++;
            $display("FAIL start_ignored_count: got %0d want %0d", strobes.size(), exp_q.size());
        end
        for (int i = 0; i < strobes.size() && i < exp_q.size(); i++) begin
            checks++;
            if (strobes[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL start_ignored_%0d: got %03h want %03h", i, strobes[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_ack_at_timeout();
        bit expired;
        special_en    = 1'b1;
        special_data  = 8'h29;
        special_delay = TO;
        clear_log();
        pulse_start();
        wait_end(8000, expired);
        special_en = 1'b0;
        checks++;
        if (expired || o_error !== 1'b0 || o_done !== 1'b1) begin
            errors++;
            $display("FAIL ack_at_timeout: got done=%0b error=%0b want 1 0", o_done, o_error);
        end
        checks++;
        if (strobes.size() != exp_q.size()) begin
            errors++;
            $display("FAIL ack_at_timeout_count: got %0d want %0d", strobes.size(), exp_q.size());
        end
    endtask

    task automatic test_timeout();
        bit expired;
        special_en    = 1'b1;
        special_data  = 8'h11;
        special_delay = -1;
        clear_log();
        pulse_start();
        wait_end(6000, expired);
        special_en = 1'b0;
        checks++;
        if (expired || {o_error, o_chip_select, o_busy, o_done} !== 4'b1000) begin
            errors++;
            $display("FAIL timeout_state: got err/cs/busy/done=%04b want 1000",
                     {o_error, o_chip_select, o_busy, o_done});
        end
        checks++;
        if (strobe_t.size() != 2) begin
            errors++;
            $display("FAIL timeout_strobes: got %0d want 2", strobe_t.size());
        end else if (t_err - strobe_t[1] != TO + 1) begin
            errors++;
            $display("FAIL timeout_latency: got %0d want %0d", t_err - strobe_t[1], TO + 1);
        end
        clear_log();
        pulse_start();
        checks++;
        if (o_error !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_clears: got error=%0b busy=%0b want 0 1", o_error, o_busy);
        end
        wait_end(6000, expired);
        checks++;
        if (expired || o_done !== 1'b1 || strobes.size() != exp_q.size()) begin
            errors++;
            $display("FAIL restart_finish: got done=%0b strobes=%0d want 1 %0d",
                     o_done, strobes.size(), exp_q.size());
        end
    endtask

    task automatic test_async_reset();
        int n = 0;
        clear_log();
        pulse_start();
        while (strobes.size() < 2 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (100) @(negedge clk);
        checks++;
        if (o_busy !== 1'b1 || o_chip_select !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_busy: got busy=%0b cs=%0b want 1 1", o_busy, o_chip_select);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (out_vec() !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset: got %04h want 0000", out_vec());
        end
        @(negedge clk);
        rst = 1'b1;
        clear_log();
        repeat (300) @(negedge clk);
        checks++;
        if (out_vec() !== 16'h0000 || strobes.size() != 0) begin
            errors++;
            $display("FAIL post_reset_idle: got %04h strobes %0d want 0000 0",
                     out_vec(), strobes.size());
        end
    endtask

    initial begin
        build_expected();
        clear_log();
        test_reset();
        test_normal();
        test_start_ignored();
        test_ack_at_timeout();
        test_timeout();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
